// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and constants for the FIFO burst reader: FSM state encoding,
// output queue depth and counter widths.
package fifo_burst_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int OUT_DEPTH   = 2;
    localparam int BURST_CNT_W = 4;
    localparam int FIFO_CNT_W  = 4;
    localparam int Q_CNT_W     = $clog2(OUT_DEPTH + 1);
    localparam int Q_PTR_W     = $clog2(OUT_DEPTH);

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Bundle of the FIFO-side and stream-side signals of the burst reader.
// master = the reader, slave = the FIFO plus downstream consumer.
interface fifo_burst_reader_if
    import fifo_burst_reader_pkg::*;
#(
    parameter int Num_of_bits = 8
);
    logic                   fifo_empty;
    logic [FIFO_CNT_W-1:0]  fifo_counter;
    logic [Num_of_bits-1:0] fifo_out;
    logic                   flush;
    logic                   read_enable;
    logic [Num_of_bits-1:0] out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;
    logic [BURST_CNT_W-1:0] burst_count;

    modport master (
        input  fifo_empty, fifo_counter, fifo_out, flush, out_ready,
        output read_enable, out_data, out_valid, busy, burst_count
    );

    modport slave (
        output fifo_empty, fifo_counter, fifo_out, flush, out_ready,
        input  read_enable, out_data, out_valid, busy, burst_count
    );
endinterface

// File: rtl/fifo_burst_reader_skid.sv
// Two-entry FIFO-ordered output queue (push, pop, head, occupancy).
// A push and pop on the same edge keep the occupancy unchanged.
module fifo_burst_reader_skid
    import fifo_burst_reader_pkg::*;
#(
    parameter int Num_of_bits = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [Num_of_bits-1:0] i_data,
    output logic [Num_of_bits-1:0] o_head,
    output logic                   o_valid,
    output logic [Q_CNT_W-1:0]     o_count
);
    logic [Num_of_bits-1:0] r_mem [OUT_DEPTH];
    logic [Q_PTR_W-1:0]     r_rd_ptr;
    logic [Q_CNT_W-1:0]     r_count;
    logic [Q_PTR_W-1:0]     w_wr_ptr;

    // Depth is a power of two, so the write slot wraps naturally.
    assign w_wr_ptr = r_rd_ptr + r_count[Q_PTR_W-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[w_wr_ptr] <= i_data;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst reader: pops Burst_len words from a FIFO into a 2-entry output queue.
// Optional idle timeout for partial bursts: define FIFO_BURST_READER_TIMEOUT_EN.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int Num_of_bits = 8,
    parameter int Burst_len   = 4,
    parameter int Timeout     = 15
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    fifo_burst_reader_if.master  io_bus
);
    localparam logic [BURST_CNT_W-1:0] BURST_LEN_C = BURST_CNT_W'(Burst_len);
    localparam logic [FIFO_CNT_W-1:0]  FIFO_LEN_C  = FIFO_CNT_W'(Burst_len);

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_inflight;
    logic [BURST_CNT_W-1:0] r_burst_count;
    logic                   r_soft_start;

    logic                   w_read;
    logic                   w_pop;
    logic                   w_q_valid;
    logic [Q_CNT_W-1:0]     w_q_count;
    logic [Num_of_bits-1:0] w_head;
    logic [2:0]             w_occ;
    logic                   w_thresh;
    logic                   w_flush_start;
    logic                   w_timeout_hit;

    assign w_pop         = w_q_valid && io_bus.out_ready;
    assign w_occ         = {1'b0, w_q_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_thresh      = (io_bus.fifo_counter >= FIFO_LEN_C);
    assign w_flush_start = io_bus.flush && !io_bus.fifo_empty;

    // Pop only while the queue plus the word in flight leaves a free slot.
    assign w_read = (r_state == ST_BURST) && !io_bus.fifo_empty
                    && (w_occ < 3'd2) && (r_burst_count < BURST_LEN_C);

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    localparam int                TO_W       = $clog2(Timeout + 1);
    localparam logic [TO_W-1:0]   TIMEOUT_M1 = TO_W'(Timeout - 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            w_to_cond;

    assign w_to_cond     = (r_state == ST_IDLE) && !io_bus.fifo_empty && !w_thresh;
    assign w_timeout_hit = w_to_cond && (r_to_cnt == TIMEOUT_M1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt <= '0;
        end else if (w_to_cond && !w_timeout_hit) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end
`else
    assign w_timeout_hit = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_thresh || w_flush_start || w_timeout_hit) begin
                    w_state_next = ST_BURST;
                end
            end
            ST_BURST: begin
                if (w_read && ((r_burst_count + 1'b1) == BURST_LEN_C)) begin
                    w_state_next = ST_DRAIN;
                end else if (r_soft_start && io_bus.fifo_empty && !w_read) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!r_inflight) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_inflight    <= 1'b0;
            r_burst_count <= '0;
            r_soft_start  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_read;
            if (w_read) begin
                r_burst_count <= r_burst_count + 1'b1;
            end else if (w_state_next == ST_IDLE) begin
                r_burst_count <= '0;
            end
            // A burst not started by the threshold may end early on an empty FIFO.
            if (r_state == ST_IDLE && w_state_next == ST_BURST) begin
                r_soft_start <= !w_thresh;
            end
        end
    end

    fifo_burst_reader_skid #(
        .Num_of_bits (Num_of_bits)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (r_inflight),
        .i_pop   (w_pop),
        .i_data  (io_bus.fifo_out),
        .o_head  (w_head),
        .o_valid (w_q_valid),
        .o_count (w_q_count)
    );

    assign io_bus.read_enable = w_read;
    assign io_bus.out_data    = w_head;
    assign io_bus.out_valid   = w_q_valid;
    assign io_bus.busy        = (r_state != ST_IDLE);
    assign io_bus.burst_count = r_burst_count;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: a behavioural FIFO feeds the DUT,
// loads push expected words, a negedge monitor pops and compares transfers.
module tb_fifo_burst_reader;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   n_reads = 0;
    int   valid_seen;
    int   t0;
    logic prev_stall = 1'b0;

    logic [7:0] fifo_q [$];
    logic [7:0] exp_q [$];
    int         rd_cyc [$];
    int         out_cyc [$];

    always #5 clk = ~clk;

    fifo_burst_reader_if #(.Num_of_bits(8)) bus ();

    fifo_burst_reader #(
        .Num_of_bits (8),
        .Burst_len   (4),
        .Timeout     (15)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic load(input logic [7:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic wait_busy(input logic lvl, input int max);
        int n = 0;
        while (bus.busy !== lvl && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("wait_busy", 32'(bus.busy), 32'(lvl));
    endtask

    // Behavioural FIFO: read data updates at the edge that samples read_enable.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.read_enable && fifo_q.size() > 0) begin
            bus.fifo_out <= fifo_q.pop_front();
        end
        bus.fifo_counter <= 4'(fifo_q.size());
        bus.fifo_empty   <= (fifo_q.size() == 0);
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.read_enable) begin
                n_reads++;
                rd_cyc.push_back(cyc);
            end
            if (prev_stall) begin
                chk("valid_held", 32'(bus.out_valid), 32'd1);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'(bus.out_data), 32'hFFFF_FFFF);
                end else begin
                    chk("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
                end
                out_cyc.push_back(cyc);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_read_enable"}, 32'(bus.read_enable), 32'd0);
        chk({tag, "_out_valid"},   32'(bus.out_valid),   32'd0);
        chk({tag, "_out_data"},    32'(bus.out_data),    32'd0);
        chk({tag, "_busy"},        32'(bus.busy),        32'd0);
        chk({tag, "_burst_count"}, 32'(bus.burst_count), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Scenario 1: threshold burst, out_ready high.
        n_reads = 0; rd_cyc.delete(); out_cyc.delete();
        load(8'h11); load(8'h12); load(8'h13); load(8'h14);
        wait_busy(1'b1, 20);
        wait_busy(1'b0, 40);
        repeat (5) @(posedge clk); #1;
        chk("s1_reads", 32'(n_reads), 32'd4);
        chk("s1_outs", 32'(out_cyc.size()), 32'd4);
        if (rd_cyc.size() == 4 && out_cyc.size() == 4) begin
            chk("s1_read_span", 32'(rd_cyc[3] - rd_cyc[0]), 32'd3);
            chk("s1_out_span", 32'(out_cyc[3] - out_cyc[0]), 32'd3);
            chk("s1_latency", 32'(out_cyc[0] - rd_cyc[0]), 32'd2);
        end
        chk("s1_burst_count", 32'(bus.burst_count), 32'd0);
        chk("s1_sb_empty", 32'(exp_q.size()), 32'd0);

        // Scenario 2: partial fill waits, flush drains exactly what is there.
        n_reads = 0;
        load(8'h21); load(8'h22); load(8'h23);
`ifndef FIFO_BURST_READER_TIMEOUT_EN
        repeat (100) @(posedge clk); #1;
        chk("s2_no_read", 32'(n_reads), 32'd0);
        chk("s2_idle", 32'(bus.busy), 32'd0);
`endif
        bus.flush = 1'b1;
        wait_busy(1'b1, 20);
        wait_busy(1'b0, 40);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        repeat (5) @(posedge clk); #1;
        chk("s2_reads", 32'(n_reads), 32'd3);
        chk("s2_sb_empty", 32'(exp_q.size()), 32'd0);

        // Scenario 3: backpressure stalls after two reads.
        bus.out_ready = 1'b0;
        n_reads = 0;
        load(8'h31); load(8'h32); load(8'h33); load(8'h34);
        repeat (20) @(posedge clk); #1;
        chk("s3_stall_reads", 32'(n_reads), 32'd2);
        chk("s3_valid", 32'(bus.out_valid), 32'd1);
        chk("s3_busy", 32'(bus.busy), 32'd1);
        bus.out_ready = 1'b1;
        wait_busy(1'b0, 40);
        repeat (5) @(posedge clk); #1;
        chk("s3_reads", 32'(n_reads), 32'd4);
        chk("s3_sb_empty", 32'(exp_q.size()), 32'd0);

        // Scenario 6: out_ready toggling.
        n_reads = 0;
        load(8'h61); load(8'h62); load(8'h63); load(8'h64);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            bus.out_ready = ~bus.out_ready;
        end
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk); #1;
        chk("s6_reads", 32'(n_reads), 32'd4);
        chk("s6_busy", 32'(bus.busy), 32'd0);
        chk("s6_sb_empty", 32'(exp_q.size()), 32'd0);

`ifdef FIFO_BURST_READER_TIMEOUT_EN
        // Scenario 4: single word starts a burst after the idle timeout.
        n_reads = 0; rd_cyc.delete();
        t0 = cyc;
        load(8'hAB);
        for (int i = 0; i < 40 && n_reads == 0; i++) @(negedge clk);
        chk("s4_read_seen", 32'(n_reads > 0), 32'd1);
        // FIFO level visible one edge after load, then 15 idle cycles.
        if (rd_cyc.size() > 0) chk("s4_read_time", 32'(rd_cyc[0] - t0), 32'd16);
        wait_busy(1'b0, 20);
        repeat (5) @(posedge clk); #1;
        chk("s4_sb_empty", 32'(exp_q.size()), 32'd0);
`endif

        // Scenario 5: reset after the second read of a burst.
        n_reads = 0;
        load(8'h51); load(8'h52); load(8'h53); load(8'h54);
        for (int i = 0; i < 40 && n_reads < 2; i++) @(negedge clk);
        chk("s5_two_reads", 32'(n_reads >= 2), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        fifo_q.delete();
        @(negedge clk);
        chk_reset_outputs("s5_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        valid_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) valid_seen++;
        end
        chk("s5_no_stale_valid", 32'(valid_seen), 32'd0);
        chk("s5_idle", 32'(bus.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
